// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: streaming symbol matcher against a programmable DEPTH-symbol pattern
module seq_pattern_detector #(
  parameter int WIDTH   = 3,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1,
  localparam int IW = $clog2(DEPTH),
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_sym,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [FW-1:0]    fill
);
  logic [WIDTH-1:0] pat_q  [DEPTH];
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, eq, acc, hit;
  // Window compared against the pattern: the last DEPTH-1 held symbols plus the incoming one
  always_comb begin
    eq = in_data == pat_q[DEPTH-1];
    for (int i = 0; i < DEPTH - 1; i++) eq = eq && (hist_q[i+1] == pat_q[i]);
    acc    = in_valid && !cfg_we;
    hit    = acc && eq && (fill_q >= FW'(DEPTH - 1));
    fill_d = cfg_we ? '0 :
             !acc ? fill_q :
             (hit && OVERLAP == 0) ? '0 :
             (fill_q == FW'(DEPTH)) ? fill_q : fill_q + 1'b1;
    cnt_d  = clr_cnt ? '0 : (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i]  <= '0;
        hist_q[i] <= '0;
      end
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      if (cfg_we && 32'(cfg_idx) < DEPTH) pat_q[cfg_idx] <= cfg_sym;
      if (acc) begin
        for (int i = 0; i < DEPTH - 1; i++) hist_q[i] <= hist_q[i+1];
        hist_q[DEPTH-1] <= in_data;
      end
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= hit;
    end
  end
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: scoreboard bench over default, non-overlapping and narrow-counter instances
module tb_seq_pattern_detector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic       we  [3];
  logic [1:0] idx [3];
  logic [2:0] sym [3];
  logic       v   [3];
  logic [2:0] dat [3];
  logic       clr [3];
  logic       am  [3];
  logic [7:0] ac  [3];
  logic [2:0] af  [3];
  logic [1:0] cnt_c;
  typedef struct {logic m; logic [7:0] c; logic [2:0] f; int id;} exp_t;
  exp_t q [3][$];
  int total = 0;
  int passed = 0;
  int step_id = 0;
  seq_pattern_detector dut_a (
    .clk(clk), .rst(rst), .cfg_we(we[0]), .cfg_idx(idx[0]), .cfg_sym(sym[0]),
    .in_valid(v[0]), .in_data(dat[0]), .clr_cnt(clr[0]),
    .match(am[0]), .match_cnt(ac[0]), .fill(af[0]));
  seq_pattern_detector #(.OVERLAP(0)) dut_b (
    .clk(clk), .rst(rst), .cfg_we(we[1]), .cfg_idx(idx[1]), .cfg_sym(sym[1]),
    .in_valid(v[1]), .in_data(dat[1]), .clr_cnt(clr[1]),
    .match(am[1]), .match_cnt(ac[1]), .fill(af[1]));
  seq_pattern_detector #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .cfg_we(we[2]), .cfg_idx(idx[2]), .cfg_sym(sym[2]),
    .in_valid(v[2]), .in_data(dat[2]), .clr_cnt(clr[2]),
    .match(am[2]), .match_cnt(cnt_c), .fill(af[2]));
  assign ac[2] = {6'b0, cnt_c};
  task automatic quiet();
    for (int d = 0; d < 3; d++) begin
      we[d] = 0; idx[d] = 0; sym[d] = 0; v[d] = 0; dat[d] = 0; clr[d] = 0;
    end
  endtask
  task automatic drive(input int d, input logic w, input logic [1:0] i, input logic [2:0] s,
                       input logic vv, input logic [2:0] dd, input logic cl,
                       input logic em, input logic [7:0] ec, input logic [2:0] ef);
    @(negedge clk);
    quiet();
    we[d] = w; idx[d] = i; sym[d] = s; v[d] = vv; dat[d] = dd; clr[d] = cl;
    step_id++;
    q[d].push_back('{em, ec, ef, step_id});
  endtask
  task automatic sy(input int d, input logic [2:0] x, input logic em, input logic [7:0] ec, input logic [2:0] ef);
    drive(d, 0, 0, 0, 1, x, 0, em, ec, ef);
  endtask
  task automatic cf(input int d, input logic [1:0] i, input logic [2:0] s, input logic cl, input logic [7:0] ec);
    drive(d, 1, i, s, 0, 0, cl, 0, ec, 0);
  endtask
  task automatic id(input int d, input logic [7:0] ec, input logic [2:0] ef);
    drive(d, 0, 0, 0, 0, 0, 0, 0, ec, ef);
  endtask
  task automatic load(input int d, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                      input logic [2:0] e, input logic cl);
    cf(d, 0, a, cl, cl ? 8'd0 : ac[d]);
    cf(d, 1, b, 0, cl ? 8'd0 : ac[d]);
    cf(d, 2, c, 0, cl ? 8'd0 : ac[d]);
    cf(d, 3, e, 0, cl ? 8'd0 : ac[d]);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (q[d].size() > 0) begin
          e = q[d].pop_front();
          total++;
          if (am[d] === e.m && ac[d] === e.c && af[d] === e.f) passed++;
          else $display("FAIL dut%0d step%0d: got match=%0d cnt=%0d fill=%0d, expected match=%0d cnt=%0d fill=%0d",
                        d, e.id, am[d], ac[d], af[d], e.m, e.c, e.f);
        end
      end
    end
  end
  initial begin
    int budget;
    quiet();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    id(0, 0, 0);
    cf(0, 0, 1, 0, 0); cf(0, 1, 3, 0, 0); cf(0, 2, 3, 0, 0); cf(0, 3, 7, 0, 0);
    sy(0, 1, 0, 0, 1); sy(0, 3, 0, 0, 2); sy(0, 3, 0, 0, 3); sy(0, 7, 1, 1, 4);
    id(0, 1, 4);
    cf(0, 0, 1, 1, 0);
    sy(0, 1, 0, 0, 1); sy(0, 3, 0, 0, 2);
    id(0, 0, 2); id(0, 0, 2); id(0, 0, 2);
    sy(0, 3, 0, 0, 3); sy(0, 7, 1, 1, 4);
    cf(0, 0, 5, 1, 0); cf(0, 1, 5, 0, 0); cf(0, 2, 5, 0, 0); cf(0, 3, 5, 0, 0);
    sy(0, 5, 0, 0, 1); sy(0, 5, 0, 0, 2); sy(0, 5, 0, 0, 3);
    sy(0, 5, 1, 1, 4); sy(0, 5, 1, 2, 4); sy(0, 5, 1, 3, 4);
    id(0, 3, 4);
    cf(0, 0, 1, 1, 0); cf(0, 1, 3, 0, 0); cf(0, 2, 3, 0, 0); cf(0, 3, 7, 0, 0);
    sy(0, 1, 0, 0, 1); sy(0, 3, 0, 0, 2); sy(0, 3, 0, 0, 3);
    drive(0, 1, 0, 1, 1, 7, 0, 0, 0, 0);
    sy(0, 7, 0, 0, 1);
    sy(0, 3, 0, 0, 2); sy(0, 3, 0, 0, 3); sy(0, 7, 0, 0, 4);
    sy(0, 1, 0, 0, 4); sy(0, 3, 0, 0, 4); sy(0, 3, 0, 0, 4); sy(0, 7, 1, 1, 4);
    cf(1, 0, 5, 0, 0); cf(1, 1, 5, 0, 0); cf(1, 2, 5, 0, 0); cf(1, 3, 5, 0, 0);
    sy(1, 5, 0, 0, 1); sy(1, 5, 0, 0, 2); sy(1, 5, 0, 0, 3);
    sy(1, 5, 1, 1, 0); sy(1, 5, 0, 1, 1); sy(1, 5, 0, 1, 2);
    id(1, 1, 2);
    sy(1, 5, 0, 1, 3); sy(1, 5, 1, 2, 0);
    cf(2, 0, 5, 0, 0); cf(2, 1, 5, 0, 0); cf(2, 2, 5, 0, 0); cf(2, 3, 5, 0, 0);
    sy(2, 5, 0, 0, 1); sy(2, 5, 0, 0, 2); sy(2, 5, 0, 0, 3);
    sy(2, 5, 1, 1, 4); sy(2, 5, 1, 2, 4); sy(2, 5, 1, 3, 4); sy(2, 5, 1, 3, 4); sy(2, 5, 1, 3, 4);
    drive(2, 0, 0, 0, 1, 5, 1, 1, 0, 4);
    sy(2, 5, 1, 1, 4);
    sy(0, 1, 0, 1, 4); sy(0, 3, 0, 1, 4); sy(0, 3, 0, 1, 4);
    @(negedge clk);
    quiet();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    id(0, 0, 0); id(1, 0, 0); id(2, 0, 0);
    cf(0, 0, 1, 0, 0); cf(0, 1, 3, 0, 0); cf(0, 2, 3, 0, 0); cf(0, 3, 7, 0, 0);
    sy(0, 7, 0, 0, 1);
    @(negedge clk);
    quiet();
    budget = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) begin
      total++;
      $display("FAIL drain: %0d entries left, expected 0", q[0].size() + q[1].size() + q[2].size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seq_pattern_detector.md
SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 3, giving the bits per input symbol.
REQ-002 The block SHALL have a parameter DEPTH, default 4 (minimum 2), giving the pattern length in symbols.
REQ-003 The block SHALL have a parameter CNT_W, default 8, giving the match counter width.
REQ-004 The block SHALL have a parameter OVERLAP, default 1; 1 means overlapping matches, 0 means non-overlapping.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port clk: input, 1 bit, sole clock, rising edge.
REQ-007 Port rst: input, 1 bit, asynchronous active-low reset.
REQ-008 Port cfg_we: input, 1 bit, pattern write strobe.
REQ-009 Port cfg_idx: input, clog2(DEPTH) bits, pattern slot to write.
REQ-010 Port cfg_sym: input, WIDTH bits, symbol value to write.
REQ-011 Port in_valid: input, 1 bit, in_data is a valid symbol this cycle.
REQ-012 Port in_data: input, WIDTH bits, stream symbol.
REQ-013 Port clr_cnt: input, 1 bit, synchronous clear of match_cnt.
REQ-014 Port match: output, 1 bit, registered one-cycle match pulse.
REQ-015 Port match_cnt: output, CNT_W bits, saturating count of matches.
REQ-016 Port fill: output, clog2(DEPTH+1) bits, number of valid symbols held in history, 0..DEPTH.

Function
REQ-017 Pattern storage SHALL be DEPTH registers pat[0..DEPTH-1]; pat[0] is the oldest (first-arriving) symbol and pat[DEPTH-1] the newest.
REQ-018 A rising edge with cfg_we=1 SHALL write cfg_sym to pat[cfg_idx]; writes with cfg_idx>=DEPTH SHALL be ignored.
REQ-019 A rising edge with cfg_we=1 SHALL set fill to 0 and discard any in_valid symbol in that cycle (history flush).
REQ-020 A rising edge with in_valid=1 and cfg_we=0 SHALL shift in_data into a DEPTH-entry history and set fill to min(fill+1, DEPTH).
REQ-021 A match SHALL be detected on an accepted symbol when fill>=DEPTH-1 before the edge, and the previous DEPTH-1 symbols plus in_data equal pat[0..DEPTH-1] in order.
REQ-022 On a detected match, match SHALL be 1 for exactly the cycle following the accepting edge (latency 1); otherwise match SHALL be 0.
REQ-023 With in_valid=0, history and fill SHALL hold and match SHALL be 0 on the next cycle; gaps between valid symbols SHALL NOT break a match.
REQ-024 With OVERLAP=1, fill SHALL remain DEPTH after a match, so the trailing symbols may start the next match.
REQ-025 With OVERLAP=0, fill SHALL be set to 0 on the matching edge, so the next match needs DEPTH new symbols.
REQ-026 match_cnt SHALL increment by 1 on the same edge that sets match=1, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-027 clr_cnt=1 SHALL set match_cnt to 0 on the next edge and SHALL take priority over a simultaneous increment; match SHALL still pulse.
REQ-028 The block SHALL have no other state machine states: the state is pattern, history, fill, match and match_cnt.

Reset
REQ-029 When rst=0, the block SHALL immediately and asynchronously clear pat[*], history, fill, match and match_cnt to 0.
REQ-030 A reset asserted mid-sequence SHALL discard all partial progress; the first post-reset match SHALL need DEPTH new valid symbols and a pattern reload.
REQ-031 Inputs SHALL be ignored while rst=0.

Verification
REQ-032 Basic match (defaults): load pattern 1,3,3,7; stream 1,3,3,7 back-to-back -> match=1 one cycle after the edge accepting 7; match_cnt=1; fill=4.
REQ-033 Overlap: pattern 5,5,5,5; stream six 5s -> OVERLAP=1 gives 3 match pulses and match_cnt=3; OVERLAP=0 gives 1 pulse and match_cnt=1 with fill=2.
REQ-034 Gaps: pattern 1,3,3,7; stream 1,3,(in_valid=0 for 3 cycles),3,7 -> single match, match_cnt=1.
REQ-035 Saturation and clear: CNT_W=2, 5 matches -> match_cnt=3; then clr_cnt coincident with a 6th match -> match=1 and match_cnt=0.
REQ-036 Reset mid-operation: stream 1,3,3; assert rst for 1 cycle; reload the pattern; send 7 -> no match, match_cnt=0, fill=1.
REQ-037 Configuration flush: stream 1,3,3; write pat[0]=1 via cfg_we; send 7 -> no match, fill=1.
